userid_lookup_arbiter: RTL and testbench

- Shares the single synchronous user-ID ROM between NUM_REQ login requesters.
- Arbitrates round-robin and scans ROM addresses 1..2^ADDR_W-1 for the winner's userid.
- Returns hit/miss plus internal id (matching address) with a one-cycle done pulse.
- Sits between the login front-ends and the user-ID ROM, replacing per-terminal direct ROM scanning.

---
 rtl/userid_pkg.sv | 15 +
 rtl/rr_arbiter_onehot.sv | 34 +++
 rtl/userid_lookup_arbiter.sv | 158 +++++++++++++++
 tb/tb_userid_lookup_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/userid_pkg.sv
// Shared types and defaults for the user-ID lookup arbiter.
package userid_pkg;

    localparam int unsigned ID_W_DEF      = 16;
    localparam int unsigned ADDR_W_DEF    = 4;
    localparam int unsigned RESERVED_ADDR = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_COMPARE = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

endpackage

// File: rtl/rr_arbiter_onehot.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter_onehot
    import userid_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] onehot_c,
    output logic [IDX_W-1:0]   idx_c,
    output logic               any_c
);

    logic [IDX_W-1:0] cand_c;

    always_comb begin
        any_c    = 1'b0;
        idx_c    = '0;
        onehot_c = '0;
        cand_c   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand_c = IDX_W'((32'(ptr_i) + k) % NUM_REQ);
            if (!any_c && req_i[cand_c]) begin
                any_c = 1'b1;
                idx_c = cand_c;
            end
        end
        if (any_c) begin
            onehot_c[idx_c] = 1'b1;
        end
    end

endmodule

// File: rtl/userid_lookup_arbiter.sv
// Shares one synchronous user-ID ROM between login requesters: round-robin
// grant, linear scan of addresses 1..2^ADDR_W-1, hit/miss with matching address.
module userid_lookup_arbiter
    import userid_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned ID_W    = ID_W_DEF,
    parameter int unsigned ROM_LAT = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*ID_W-1:0] req_userid,
    output logic [NUM_REQ-1:0]      gnt,
    output logic                    done,
    output logic                    hit,
    output logic [ADDR_W-1:0]       internalid,
    output logic                    busy,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [ID_W-1:0]         rom_data
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = 3;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_e              state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic                done_q, done_d;
    logic                hit_q, hit_d;
    logic [ADDR_W-1:0]   iid_q, iid_d;
    logic                busy_q, busy_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ID_W-1:0]     cur_id_q, cur_id_d;
    logic [IDX_W-1:0]    win_q, win_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;

    logic [NUM_REQ-1:0]  arb_onehot_c;
    logic [IDX_W-1:0]    arb_idx_c;
    logic                arb_any_c;
    logic [IDX_W-1:0]    ptr_adv_c;

    rr_arbiter_onehot #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .onehot_c (arb_onehot_c),
        .idx_c    (arb_idx_c),
        .any_c    (arb_any_c)
    );

    // Priority moves to the requester after the current winner.
    assign ptr_adv_c = (32'(win_q) == NUM_REQ - 1) ? '0 : win_q + IDX_W'(1);

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        hit_d    = hit_q;
        iid_d    = iid_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        cur_id_d = cur_id_q;
        win_d    = win_q;
        ptr_d    = ptr_q;

        unique case (state_q)
            ST_IDLE: begin
                if (arb_any_c) begin
                    state_d  = ST_WAIT;
                    gnt_d    = arb_onehot_c;
                    win_d    = arb_idx_c;
                    cur_id_d = req_userid[arb_idx_c*ID_W +: ID_W];
                    addr_d   = ADDR_W'(1);
                    cnt_d    = CNT_W'(ROM_LAT - 1);
                end
            end
            ST_WAIT: begin
                if (!req[win_q]) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    ptr_d   = ptr_adv_c;
                end else if (cnt_q == '0) begin
                    state_d = ST_COMPARE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_COMPARE: begin
                if (!req[win_q]) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    ptr_d   = ptr_adv_c;
                end else if (rom_data == cur_id_q) begin
                    state_d = ST_RESP;
                    hit_d   = 1'b1;
                    iid_d   = addr_q;
                end else if (addr_q == LAST_ADDR) begin
                    // Scan ends at the top address; address 0 is never visited.
                    state_d = ST_RESP;
                    hit_d   = 1'b0;
                    iid_d   = ADDR_W'(RESERVED_ADDR);
                end else begin
                    state_d = ST_WAIT;
                    addr_d  = addr_q + ADDR_W'(1);
                    cnt_d   = CNT_W'(ROM_LAT - 1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                ptr_d   = ptr_adv_c;
            end
        endcase

        done_d = (state_d == ST_RESP);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            done_q   <= 1'b0;
            hit_q    <= 1'b0;
            iid_q    <= '0;
            busy_q   <= 1'b0;
            addr_q   <= '0;
            cnt_q    <= '0;
            cur_id_q <= '0;
            win_q    <= '0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            hit_q    <= hit_d;
            iid_q    <= iid_d;
            busy_q   <= busy_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            cur_id_q <= cur_id_d;
            win_q    <= win_d;
            ptr_q    <= ptr_d;
        end
    end

    assign gnt        = gnt_q;
    assign done       = done_q;
    assign hit        = hit_q;
    assign internalid = iid_q;
    assign busy       = busy_q;
    assign rom_addr   = addr_q;

endmodule

// File: tb/tb_userid_lookup_arbiter.sv
// Bench for userid_lookup_arbiter: directed table, corner sequences and
// random rounds against a scan-level reference model with a latency-ROM model.
module tb_userid_lookup_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 4;
    localparam int ID_W    = 16;
    localparam int ROM_LAT = 2;
    localparam int NADDR   = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [63:0] req_userid;
    logic [3:0]  gnt;
    logic        done;
    logic        hit;
    logic [3:0]  internalid;
    logic        busy;
    logic [3:0]  rom_addr;
    logic [15:0] rom_data;

    logic [15:0] mem [NADDR];
    logic [3:0]  apipe [ROM_LAT];

    int          errors = 0;
    int          checks = 0;
    int          mptr = 0;
    logic        m_hit = 1'b0;
    logic [3:0]  m_iid = 4'd0;
    int          last_win;
    int          obs_lat;
    logic        obs_hit;
    logic [3:0]  obs_iid;

    typedef struct {
        logic [3:0]  mask;
        int          win;
        logic [15:0] uid;
        logic        exp_hit;
        logic [3:0]  exp_iid;
        int          exp_lat;
    } vec_t;

    vec_t tbl [5];

    userid_lookup_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .ID_W    (ID_W),
        .ROM_LAT (ROM_LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_userid (req_userid),
        .gnt        (gnt),
        .done       (done),
        .hit        (hit),
        .internalid (internalid),
        .busy       (busy),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data)
    );

    always #5 clk = ~clk;

    // ROM whose data follows the address by ROM_LAT clock edges.
    always @(posedge clk) begin
        apipe[0] <= rom_addr;
        for (int i = 1; i < ROM_LAT; i++) apipe[i] <= apipe[i-1];
    end
    assign rom_data = mem[apipe[ROM_LAT-1]];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] m, input int p);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (m[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic int exp_addr(input logic [15:0] u);
        for (int a = 1; a < NADDR; a++) begin
            if (mem[a] == u) return a;
        end
        return 0;
    endfunction

    function automatic logic [15:0] uid_of(input int i);
        logic [63:0] v;
        v = req_userid;
        return v[i*16 +: 16];
    endfunction

    // Starts at a negedge in an IDLE cycle with req applied; ends at the
    // negedge of the IDLE cycle after done with the winner's req dropped.
    task automatic serve(input string nm);
        int   w;
        int   a;
        int   lat;
        logic gbad;
        logic addr0;
        w = rr_pick(req, mptr);
        last_win = w;
        if (w < 0) begin
            check({nm, " no requester"}, 32'd0, 32'd1);
            return;
        end
        a       = exp_addr(uid_of(w));
        lat     = ((a == 0) ? (NADDR - 1) : a) * (ROM_LAT + 1) + 1;
        gbad    = 1'b0;
        addr0   = 1'b0;
        obs_lat = -1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (busy && rom_addr == 4'd0) addr0 = 1'b1;
            if (gnt != 4'(1 << w)) gbad = 1'b1;
            if (done) begin
                obs_lat = c;
                obs_hit = hit;
                obs_iid = internalid;
                break;
            end
        end
        check({nm, " done cycle"}, 32'(obs_lat), 32'(lat));
        if (obs_lat < 0) begin
            req[w] = 1'b0;
            return;
        end
        check({nm, " gnt onehot"}, 32'(gbad), 32'd0);
        check({nm, " rom_addr nonzero"}, 32'(addr0), 32'd0);
        check({nm, " busy at done"}, 32'(busy), 32'd1);
        check({nm, " hit"}, 32'(obs_hit), 32'(a != 0));
        check({nm, " internalid"}, 32'(obs_iid), 32'(a));
        m_hit  = (a != 0);
        m_iid  = 4'(a);
        mptr   = (w + 1) % NUM_REQ;
        req[w] = 1'b0;
        @(negedge clk);
        check({nm, " done one-shot"}, 32'(done), 32'd0);
        check({nm, " gnt released"}, 32'(gnt), 32'd0);
        check({nm, " busy idle"}, 32'(busy), 32'd0);
        check({nm, " hit held"}, 32'(hit), 32'(m_hit));
        check({nm, " iid held"}, 32'(internalid), 32'(m_iid));
    endtask

    task automatic wait_addr(input string nm, input logic [3:0] target);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rom_addr != target && n < 100);
        check({nm, " reached rom_addr"}, 32'(rom_addr), 32'(target));
    endtask

    task automatic set_uid(input int i, input logic [15:0] u);
        req_userid[i*16 +: 16] = u;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NADDR; i++) mem[i] = 16'(16'h0100 * i + 16'h0011);
        mem[0]  = 16'hAAAA;
        mem[3]  = 16'hBEEF;
        mem[9]  = 16'hAAAA;
        mem[12] = 16'hAAAA;
        mem[15] = 16'h5A5A;

        tbl[0] = '{mask: 4'b0001, win: 0, uid: 16'hBEEF, exp_hit: 1'b1, exp_iid: 4'd3,  exp_lat: 10};
        tbl[1] = '{mask: 4'b0100, win: 2, uid: 16'h1234, exp_hit: 1'b0, exp_iid: 4'd0,  exp_lat: 46};
        tbl[2] = '{mask: 4'b0001, win: 0, uid: 16'hAAAA, exp_hit: 1'b1, exp_iid: 4'd9,  exp_lat: 28};
        tbl[3] = '{mask: 4'b0010, win: 1, uid: 16'h5A5A, exp_hit: 1'b1, exp_iid: 4'd15, exp_lat: 46};
        tbl[4] = '{mask: 4'b1000, win: 3, uid: 16'h0111, exp_hit: 1'b1, exp_iid: 4'd1,  exp_lat: 4};

        reset      = 1'b0;
        req        = 4'b0000;
        req_userid = '0;
        repeat (3) @(negedge clk);
        check("reset gnt", 32'(gnt), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset hit", 32'(hit), 32'd0);
        check("reset iid", 32'(internalid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset rom_addr", 32'(rom_addr), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("idle no req busy", 32'(busy), 32'd0);
        check("idle rom_addr holds", 32'(rom_addr), 32'd0);

        // Directed table.
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < NUM_REQ; i++) set_uid(i, 16'($urandom));
            set_uid(tbl[v].win, tbl[v].uid);
            req = tbl[v].mask;
            serve($sformatf("tbl%0d", v));
            check($sformatf("tbl%0d winner", v), 32'(last_win), 32'(tbl[v].win));
            check($sformatf("tbl%0d latency", v), 32'(obs_lat), 32'(tbl[v].exp_lat));
            check($sformatf("tbl%0d hit", v), 32'(obs_hit), 32'(tbl[v].exp_hit));
            check($sformatf("tbl%0d iid", v), 32'(obs_iid), 32'(tbl[v].exp_iid));
        end

        // Round-robin with all four held.
        set_uid(0, 16'hBEEF);
        set_uid(1, 16'h0111);
        set_uid(2, 16'h0211);
        set_uid(3, 16'h0411);
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            serve($sformatf("rr%0d", k));
            check($sformatf("rr%0d order", k), 32'(last_win), 32'(k));
        end
        req = 4'b0101;
        serve("rr re0");
        check("rr re0 order", 32'(last_win), 32'd0);
        serve("rr re2");
        check("rr re2 order", 32'(last_win), 32'd2);

        // Abort during WAIT at rom_addr 5.
        set_uid(1, 16'h1234);
        req = 4'b0010;
        check("abort winner model", 32'(rr_pick(req, mptr)), 32'd1);
        wait_addr("abort", 4'd5);
        check("abort gnt before", 32'(gnt), 32'b0010);
        set_uid(0, 16'hBEEF);
        set_uid(3, 16'h0111);
        req = 4'b1001;
        @(negedge clk);
        check("abort gnt cleared", 32'(gnt), 32'd0);
        check("abort no done", 32'(done), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort hit kept", 32'(hit), 32'(m_hit));
        check("abort iid kept", 32'(internalid), 32'(m_iid));
        mptr = 2;
        serve("abort next");
        check("abort next winner", 32'(last_win), 32'd3);
        serve("abort after");
        check("abort after winner", 32'(last_win), 32'd0);

        // Reset mid-scan at rom_addr 7.
        set_uid(0, 16'h1234);
        set_uid(3, 16'h1234);
        req = 4'b1001;
        wait_addr("rst", 4'd7);
        check("rst scan winner", 32'(gnt), 32'b1000);
        reset = 1'b0;
        @(negedge clk);
        check("rst gnt", 32'(gnt), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst hit", 32'(hit), 32'd0);
        check("rst iid", 32'(internalid), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst rom_addr", 32'(rom_addr), 32'd0);
        reset = 1'b1;
        mptr  = 0;
        m_hit = 1'b0;
        m_iid = 4'd0;
        serve("rst first");
        check("rst first winner", 32'(last_win), 32'd0);
        serve("rst second");
        check("rst second winner", 32'(last_win), 32'd3);

        // Random rounds.
        for (int r = 0; r < 30; r++) begin
            logic [3:0] m;
            int         guard;
            repeat (3) mem[$urandom_range(0, NADDR - 1)] = 16'($urandom);
            m = 4'($urandom_range(1, 15));
            for (int i = 0; i < NUM_REQ; i++) begin
                case ($urandom_range(0, 3))
                    0: set_uid(i, mem[$urandom_range(0, NADDR - 1)]);
                    1: set_uid(i, 16'($urandom));
                    2: set_uid(i, mem[$urandom_range(1, NADDR - 1)]);
                    default: set_uid(i, mem[0]);
                endcase
            end
            req   = m;
            guard = 0;
            while (req != 4'b0000 && guard < 8) begin
                serve($sformatf("rnd%0d.%0d", r, guard));
                guard++;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
